// File: rtl/tpu_mvu_if.sv
// Instruction / read-back bus of the matrix-vector unit.
interface tpu_mvu_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  result;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output instr, instr_valid,
    input  result, busy, done, err
  );

  modport slave (
    input  instr, instr_valid,
    output result, busy, done, err
  );
endinterface

// File: rtl/tpu_mvu.sv
// Small matrix-vector unit: y = W*x (optionally accumulated), one MAC per cycle.
module tpu_mvu #(
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned SIGNED = 1
) (
  input logic       clk,
  input logic       rst_n,
  tpu_mvu_if.slave  bus
);

  localparam int unsigned AW = 2 * DW + 2;
  localparam int unsigned NB = (AW + 7) / 8;
  localparam int unsigned RW = $clog2(N);

  localparam logic [2:0] OP_LDW  = 3'b001;
  localparam logic [2:0] OP_LDX  = 3'b010;
  localparam logic [2:0] OP_RUN  = 3'b011;
  localparam logic [2:0] OP_READ = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_RELU = 3'b110;

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] w_q [N][N];
  logic [DW-1:0] w_d [N][N];
  logic [DW-1:0] x_q [N];
  logic [DW-1:0] x_d [N];
  logic [AW-1:0] y_q [N];
  logic [AW-1:0] y_d [N];
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic          acc_q, acc_d;
  logic [7:0]    result_q, result_d;
  logic          err_q, err_d;

  logic          accept_c, last_c;
  logic [2:0]    op_c;
  logic [AW-1:0] prod_c;
  logic          unused_c;

  // Operand extension to accumulator width, sign- or zero-filled.
  function automatic logic [AW-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED != 0) return {{(AW-DW){v[DW-1]}}, v};
    else             return {{(AW-DW){1'b0}}, v};
  endfunction

  assign op_c     = bus.instr[15:13];
  assign accept_c = bus.instr_valid && (state_q != COMPUTE);
  assign last_c   = (row_q == RW'(N - 1)) && (col_q == RW'(N - 1));
  assign prod_c   = ext(w_q[row_q][col_q]) * ext(x_q[col_q]);
  assign unused_c = ^bus.instr;

  assign bus.result = result_q;
  assign bus.err    = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a RUN accepted in FINISH restarts immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c && op_c == OP_RUN) state_d = COMPUTE;
      COMPUTE: if (last_c) state_d = FINISH;
      FINISH:  state_d = (accept_c && op_c == OP_RUN) ? COMPUTE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      COMPUTE: bus.busy = 1'b1;
      FINISH:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: MAC sweep while computing, instruction decode otherwise.
  always_comb begin
    w_d      = w_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    if (state_q == COMPUTE) begin
      if (bus.instr_valid) err_d = 1'b1;
      if (col_q == '0 && !acc_q) y_d[row_q] = prod_c;
      else                       y_d[row_q] = y_q[row_q] + prod_c;
      if (col_q == RW'(N - 1)) begin
        col_d = '0;
        row_d = last_c ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (accept_c) begin
      case (op_c)
        OP_LDW: begin
          for (int unsigned r = 0; r < N; r++)
            for (int unsigned c = 0; c < N; c++)
              if (32'(bus.instr[11:8]) == r * N + c) w_d[r][c] = bus.instr[DW-1:0];
        end
        OP_LDX: begin
          for (int unsigned i = 0; i < N; i++)
            if (32'(bus.instr[9:8]) == i) x_d[i] = bus.instr[DW-1:0];
        end
        OP_RUN: begin
          acc_d = bus.instr[0];
          row_d = '0;
          col_d = '0;
        end
        OP_READ: begin
          result_d = 8'h00;
          for (int unsigned i = 0; i < N; i++)
            for (int unsigned b = 0; b < NB; b++)
              if (32'(bus.instr[9:8]) == i && 32'(bus.instr[1:0]) == b)
                result_d = 8'(y_q[i] >> (8 * b));
        end
        OP_CLR: begin
          for (int unsigned r = 0; r < N; r++) begin
            x_d[r] = '0;
            y_d[r] = '0;
            for (int unsigned c = 0; c < N; c++) w_d[r][c] = '0;
          end
          result_d = 8'h00;
          err_d    = 1'b0;
        end
        OP_RELU: begin
          if (SIGNED != 0)
            for (int unsigned i = 0; i < N; i++)
              if (y_q[i][AW-1]) y_d[i] = '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < N; r++) begin
        x_q[r] <= '0;
        y_q[r] <= '0;
        for (int unsigned c = 0; c < N; c++) w_q[r][c] <= '0;
      end
      row_q    <= '0;
      col_q    <= '0;
      acc_q    <= 1'b0;
      result_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      w_q      <= w_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/tpu_mvu.md
TPU_MVU -- requirements
Module: tpu_mvu

Interface
REQ-001 Parameter N, default 4: matrix dimension; legal range 2..4.
REQ-002 Parameter DW, default 8: element width; legal range 4..8.
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-004 Derived AW = 2*DW+2: accumulator width; NB = ceil(AW/8): readable bytes per accumulator.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 instr  input  16  instruction word.
REQ-008 instr_valid  input  1  instr is offered this cycle.
REQ-009 result  output  8  registered read-back byte.
REQ-010 busy  output  1  high while computing; instructions not accepted.
REQ-011 done  output  1  one-cycle pulse at completion of RUN.
REQ-012 err  output  1  sticky: an instruction was dropped.

Function
REQ-013 Storage SHALL be weight matrix W[N][N] (DW bits), input vector x[N] (DW bits), accumulators y[N] (AW bits).
REQ-014 Accept SHALL be instr_valid && !busy, sampled at the rising edge; opcode = instr[15:13].
REQ-015 instr_valid && busy SHALL discard the instruction, leave all storage unchanged, and set err on the next edge.
REQ-016 000 NOP, 111 reserved: no effect.
REQ-017 001 LOAD_W: W[idx/N][idx%N] <= instr[DW-1:0], idx = instr[11:8]; idx >= N*N ignored.
REQ-018 010 LOAD_X: x[instr[9:8]] <= instr[DW-1:0]; index >= N ignored.
REQ-019 011 RUN: y = W*x (instr[0]=0) or y = y + W*x (instr[0]=1).
REQ-020 100 READ: result <= byte instr[1:0] of y[instr[9:8]] on the next edge; byte >= NB or row >= N returns 0x00.
REQ-021 101 CLEAR: W, x, y, result, err <= 0 in one edge.
REQ-022 110 RELU: if SIGNED=1, every negative y[i] <= 0 in one edge; if SIGNED=0, no effect.
REQ-023 Instr bits above DW-1 in the data field SHALL be ignored.
REQ-024 FSM states SHALL be IDLE, COMPUTE, FINISH.
REQ-025 IDLE -> COMPUTE on accepted RUN; COMPUTE lasts exactly N*N cycles; COMPUTE -> FINISH; FINISH -> IDLE after one cycle.
REQ-026 In COMPUTE, one MAC per cycle in row-major order (r, c) from (0,0) to (N-1,N-1).
REQ-027 With instr[0]=0, the c=0 cycle of row r SHALL load y[r] with the product; otherwise it SHALL add the product.
REQ-028 busy SHALL equal (state == COMPUTE) combinationally.
REQ-029 done SHALL be 1 only in FINISH; instructions in FINISH SHALL be accepted.
REQ-030 SIGNED=1: operands sign-extended to AW before multiply and add; SIGNED=0: zero-extended.
REQ-031 Accumulation SHALL wrap modulo 2^AW; there is no saturation.
REQ-032 result SHALL hold its value until the next READ, CLEAR or reset.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE and clear W, x, y, the MAC counters, result, busy, done and err.
REQ-034 Reset during COMPUTE SHALL abort the operation with no done pulse; y reads 0 after reset.

Verification (N=4, DW=8, SIGNED=1)
REQ-035 Reset: assert rst_n=0 mid-cycle -> result=0x00, busy=0, done=0 and err=0 without waiting for a clock edge.
REQ-036 Identity and read-back:
- stimulus: W = identity; x = {1,2,3,4}; RUN.
- response: busy high 16 cycles, then done pulses for 1 cycle.
- then READ row2 byte0 -> result=0x03; READ row2 byte3 -> 0x00.
REQ-037 Signed extremes:
- stimulus: all W = 0x80; all x = 0x80; RUN.
- response: y0 = 65536; bytes 0/1/2 read 0x00/0x00/0x01.
- then W = 0xFF, x0 = 0x01, all other W and x = 0, RUN; READ row0 byte0 -> 0xFF.
- then RELU; row0 bytes 0..2 read 0x00.
REQ-038 Accumulate:
- stimulus: identity W; x = {5,0,0,0}; RUN with instr[0]=0, then RUN with instr[0]=1.
- response: y0 = 10; a third RUN with instr[0]=0 gives y0 = 5.
REQ-039 Busy drop:
- stimulus: LOAD_W idx0 = 0x77 issued during COMPUTE.
- response: err=1 from the next edge; W00 unchanged after done; CLEAR -> err=0.
REQ-040 Reset mid-RUN: rst_n low at COMPUTE cycle 7 -> no done pulse, busy=0, all reads 0x00.
